// File: rtl/ieee_sub_seq_if.sv
// Handshake bundle for the sequential single-precision subtractor.
// master = operand source / result consumer, slave = the subtractor.
interface ieee_sub_seq_if;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out;

   modport master (output in_valid, a, b, out_ready,
                   input  in_ready, out_valid, out);
   modport slave  (input  in_valid, a, b, out_ready,
                   output in_ready, out_valid, out);
endinterface

// File: rtl/ieee_sub_seq.sv
// Multi-cycle IEEE-754 single subtractor (a + (-b)): align, add, iterative normalise.
// Truncating, denormals flushed to zero, inf/NaN inputs not special-cased.
module ieee_sub_seq #(
   parameter int exponent = 8,
   parameter int mantissa = 23
) (
   input logic          clk,
   input logic          rst,
   ieee_sub_seq_if.slave bus
);
   localparam int EW = exponent;
   localparam int MW = mantissa;
   localparam int W  = 1 + EW + MW;

   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, DONE} state_t;

   state_t          state_reg, state_next;
   logic [W-1:0]    a_reg, a_next;
   logic [W-1:0]    b_reg, b_next;
   logic            sign_reg, sign_next;
   logic            sub_reg, sub_next;
   logic [EW-1:0]   exp_reg, exp_next;
   logic [MW:0]     mx_reg, mx_next;
   logic [MW:0]     my_reg, my_next;
   logic [MW+1:0]   sum_reg, sum_next;
   logic [W-1:0]    out_reg, out_next;

   // Operand ordering: comparing {exp,frac} as one unsigned field orders by magnitude.
   logic            a_ge_b;
   logic [W-1:0]    x_op, y_op;
   logic [EW-1:0]   dif;
   logic [MW:0]     mx_full, my_full;
   logic [EW:0]     exp_inc;

   assign a_ge_b  = (a_reg[W-2:0] >= b_reg[W-2:0]);
   assign x_op    = a_ge_b ? a_reg : b_reg;
   assign y_op    = a_ge_b ? b_reg : a_reg;
   assign dif     = x_op[W-2:MW] - y_op[W-2:MW];
   assign mx_full = (x_op[W-2:MW] == '0) ? '0 : {1'b1, x_op[MW-1:0]};
   assign my_full = (y_op[W-2:MW] == '0) ? '0 : {1'b1, y_op[MW-1:0]};
   assign exp_inc = {1'b0, exp_reg} + 1'b1;

   always_comb begin
      state_next = state_reg;
      a_next     = a_reg;
      b_next     = b_reg;
      sign_next  = sign_reg;
      sub_next   = sub_reg;
      exp_next   = exp_reg;
      mx_next    = mx_reg;
      my_next    = my_reg;
      sum_next   = sum_reg;
      out_next   = out_reg;
      case (state_reg)
         IDLE: begin
            if (bus.in_valid) begin
               a_next     = bus.a;
               b_next     = {~bus.b[W-1], bus.b[W-2:0]};
               state_next = ALIGN;
            end
         end
         ALIGN: begin
            sign_next  = x_op[W-1];
            sub_next   = x_op[W-1] ^ y_op[W-1];
            exp_next   = x_op[W-2:MW];
            mx_next    = mx_full;
            my_next    = (dif >= EW'(MW + 2)) ? '0 : (my_full >> dif);
            state_next = ADD;
         end
         ADD: begin
            // X has the larger magnitude, so the difference never goes negative.
            sum_next   = sub_reg ? ({1'b0, mx_reg} - {1'b0, my_reg})
                                 : ({1'b0, mx_reg} + {1'b0, my_reg});
            state_next = NORM;
         end
         NORM: begin
            if (sum_reg == '0) begin
               out_next   = '0;
               state_next = DONE;
            end else if (sum_reg[MW+1]) begin
               if (exp_inc >= {1'b0, {EW{1'b1}}})
                  out_next = {sign_reg, {EW{1'b1}}, {MW{1'b0}}};
               else
                  out_next = {sign_reg, exp_inc[EW-1:0], sum_reg[MW:1]};
               state_next = DONE;
            end else if (sum_reg[MW]) begin
               out_next   = {sign_reg, exp_reg, sum_reg[MW-1:0]};
               state_next = DONE;
            end else if (exp_reg <= EW'(1)) begin
               out_next   = '0;
               state_next = DONE;
            end else begin
               sum_next = {sum_reg[MW:0], 1'b0};
               exp_next = exp_reg - 1'b1;
            end
         end
         DONE: begin
            if (bus.out_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg <= IDLE;
         a_reg     <= '0;
         b_reg     <= '0;
         sign_reg  <= 1'b0;
         sub_reg   <= 1'b0;
         exp_reg   <= '0;
         mx_reg    <= '0;
         my_reg    <= '0;
         sum_reg   <= '0;
         out_reg   <= '0;
      end else begin
         state_reg <= state_next;
         a_reg     <= a_next;
         b_reg     <= b_next;
         sign_reg  <= sign_next;
         sub_reg   <= sub_next;
         exp_reg   <= exp_next;
         mx_reg    <= mx_next;
         my_reg    <= my_next;
         sum_reg   <= sum_next;
         out_reg   <= out_next;
      end
   end

   assign bus.in_ready  = (state_reg == IDLE);
   assign bus.out_valid = (state_reg == DONE);
   assign bus.out       = out_reg;
endmodule

// File: tb/tb_ieee_sub_seq.sv
// Directed and randomised checks of ieee_sub_seq against an arithmetic reference model.
module tb_ieee_sub_seq;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   ieee_sub_seq_if bus();
   ieee_sub_seq dut (.clk(clk), .rst(rst), .bus(bus));

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: integer magnitudes, exact leading-one search, truncated result.
   function automatic void model(input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output int lat);
      logic [31:0] bn, x, y;
      logic [63:0] mx, my, t, frac;
      int ex, ey, dif, msb, e;
      bn = {~b[31], b[30:0]};
      if (a[30:0] >= bn[30:0]) begin x = a;  y = bn; end
      else                     begin x = bn; y = a;  end
      ex = int'(x[30:23]);
      ey = int'(y[30:23]);
      mx = (ex == 0) ? 64'd0 : (64'd1 << 23) | 64'(x[22:0]);
      my = (ey == 0) ? 64'd0 : (64'd1 << 23) | 64'(y[22:0]);
      dif = ex - ey;
      my = (dif >= 25) ? 64'd0 : (my >> dif);
      t = (x[31] == y[31]) ? mx + my : mx - my;
      lat = 3;
      r = 32'd0;
      if (t != 0) begin
         msb = 0;
         for (int i = 0; i < 25; i++) if (t[i]) msb = i;
         e = ex + msb - 23;
         if (e >= 255) begin
            r = {x[31], 8'hFF, 23'd0};
         end else if (e <= 0) begin
            r = 32'd0;
            lat = 2 + ex;
         end else begin
            frac = (msb >= 23) ? (t >> (msb - 23)) : (t << (23 - msb));
            r = {x[31], 8'(e), frac[22:0]};
            lat = 3 + ((msb < 23) ? 23 - msb : 0);
         end
      end
   endfunction

   task automatic start_op(input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      check("in_ready_idle", 32'(bus.in_ready), 32'd1);
      bus.in_valid = 1'b1;
      bus.a = a;
      bus.b = b;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_valid(output int edges);
      edges = 0;
      while (edges < 100) begin
         @(posedge clk);
         #1;
         edges++;
         if (bus.out_valid) break;
      end
      if (!bus.out_valid) check("out_valid_timeout", 32'(bus.out_valid), 32'd1);
   endtask

   task automatic finish_op();
      @(negedge clk);
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("out_valid_drop", 32'(bus.out_valid), 32'd0);
      check("in_ready_back", 32'(bus.in_ready), 32'd1);
      bus.out_ready = 1'b0;
   endtask

   task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_out, input int exp_lat);
      int edges;
      start_op(a, b);
      wait_valid(edges);
      check({tag, "_out"}, bus.out, exp_out);
      check({tag, "_lat"}, 32'(edges), 32'(exp_lat));
      $display("op %s: a=%h b=%h out=%h latency=%0d", tag, a, b, bus.out, edges);
      finish_op();
   endtask

   initial begin
      logic [31:0] ra, rb, rexp;
      int rlat, edges, ea, eb, mode;
      bus.in_valid = 1'b0;
      bus.a = '0;
      bus.b = '0;
      bus.out_ready = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("reset_in_ready", 32'(bus.in_ready), 32'd1);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_out", bus.out, 32'd0);
      @(negedge clk);
      rst = 1'b1;

      run_op("three_minus_one", 32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 3);
      run_op("one_minus_one",   32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3);
      run_op("one_minus_neg1",  32'h3F80_0000, 32'hBF80_0000, 32'h4000_0000, 3);
      run_op("one_minus_1p5",   32'h3F80_0000, 32'h3FC0_0000, 32'hBF00_0000, 4);
      run_op("overflow_inf",    32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 3);
      run_op("dif_ge_25",       32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 3);
      run_op("one_ulp",         32'h3F80_0001, 32'h3F80_0000, 32'h3400_0000, 26);
      run_op("underflow",       32'h0080_0001, 32'h0080_0000, 32'h0000_0000, 3);

      // Back-pressure: result must hold and new operands must be ignored.
      start_op(32'h4040_0000, 32'h3F80_0000);
      wait_valid(edges);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.a = $urandom;
         bus.b = $urandom;
         @(posedge clk);
         #1;
         check("hold_out", bus.out, 32'h4000_0000);
         check("hold_out_valid", 32'(bus.out_valid), 32'd1);
         check("hold_in_ready", 32'(bus.in_ready), 32'd0);
      end
      bus.in_valid = 1'b0;
      $display("op hold: out=%h held 10 cycles", bus.out);
      finish_op();

      // Reset while normalising a long left-shift chain.
      start_op(32'h3F80_0001, 32'h3F80_0000);
      repeat (5) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("abort_out_valid", 32'(bus.out_valid), 32'd0);
      check("abort_in_ready", 32'(bus.in_ready), 32'd1);
      check("abort_out", bus.out, 32'd0);
      $display("op abort: reset during normalise");
      @(negedge clk);
      rst = 1'b1;
      run_op("after_reset", 32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 3);

      for (int k = 0; k < 40; k++) begin
         mode = $urandom_range(0, 3);
         ea = $urandom_range(1, 254);
         ra = {1'($urandom), 8'(ea), 23'($urandom)};
         case (mode)
            0: begin
               eb = $urandom_range(1, 254);
               rb = {1'($urandom), 8'(eb), 23'($urandom)};
            end
            1: begin
               eb = ea + $urandom_range(0, 6) - 3;
               if (eb < 1) eb = 1;
               if (eb > 254) eb = 254;
               rb = {1'($urandom), 8'(eb), 23'($urandom)};
            end
            2: rb = {ra[31], ra[30:23], ra[22:8], 8'($urandom)};
            default: begin
               ra = {1'($urandom), 8'($urandom_range(0, 3)), 23'($urandom)};
               rb = {ra[31], 8'($urandom_range(0, 3)), 23'($urandom)};
            end
         endcase
         model(ra, rb, rexp, rlat);
         run_op($sformatf("rand%0d", k), ra, rb, rexp, rlat);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
